// File: rtl/rect_reader.sv
// rect_reader: streams a rectangular region of the frame buffer in raster
// order, one scan position per clock, through the buffer's synchronous read
// port (one cycle of read latency). Positions outside the frame are skipped
// but still take their scan cycle, so scan time depends only on the size.
//
// Optional feature macro: RECT_READER_HIT_COUNT_EN adds a counter of streamed
// pixels whose colour matches key_color, exposed on hit_count.
//
// Handshake: go is a request sampled only while idle (busy low); once
// accepted, the region inputs are latched and may change. pix_valid marks
// a beat carrying pix_x/pix_y/pix_color; there is no back-pressure. done
// pulses once per accepted go (not after a reset abort).
module rect_reader #(
   parameter int FB_W = 160,
   parameter int FB_H = 120
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        go,
   input  logic [7:0]  x0,
   input  logic [6:0]  y0,
   input  logic [7:0]  width,
   input  logic [6:0]  height,
   output logic        busy,
   output logic        done,
   output logic        rd_en,
   output logic [14:0] rd_addr,
   input  logic [2:0]  rd_data,
   output logic        pix_valid,
   output logic [7:0]  pix_x,
   output logic [6:0]  pix_y,
   output logic [2:0]  pix_color,
   input  logic [2:0]  key_color,
`ifdef RECT_READER_HIT_COUNT_EN
   output logic [14:0] hit_count,
`endif
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_READ   = 2'd1,
      S_DRAIN  = 2'd2,
      S_FINISH = 2'd3
   } state_t;

   localparam logic [8:0] FB_W_L = 9'(FB_W);
   localparam logic [7:0] FB_H_L = 8'(FB_H);

   state_t      state_q, state_d;

   // Scan position and latched region bounds (end coordinates wrap).
   logic [7:0]  x_q, x0_q, xend_q;
   logic [6:0]  y_q, yend_q;

   // Read pipeline stage: position of the read issued last cycle.
   logic        pix_valid_q;
   logic [7:0]  pix_x_q;
   logic [6:0]  pix_y_q;

   logic        accept;
   logic        row_end;
   logic        last_pos;
   logic        in_frame;
   logic        rd_en_c;
   logic [14:0] addr_c;

   assign accept   = (state_q == S_IDLE) && go;
   assign row_end  = (x_q == xend_q);
   assign last_pos = row_end && (y_q == yend_q);
   assign in_frame = ({1'b0, x_q} < FB_W_L) && ({1'b0, y_q} < FB_H_L);
   assign addr_c   = 15'(y_q) * 15'(FB_W) + 15'(x_q);

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic: zero-size regions skip straight to a one-cycle finish.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (go) begin
               if ((width == 8'd0) || (height == 7'd0)) state_d = S_FINISH;
               else                                     state_d = S_READ;
            end
         end
         S_READ:   if (last_pos) state_d = S_DRAIN;
         S_DRAIN:  state_d = S_IDLE;
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Output decode: reads issue only for in-frame positions during the scan.
   always_comb begin
      busy    = (state_q != S_IDLE);
      done    = (state_q == S_DRAIN) || (state_q == S_FINISH);
      rd_en_c = (state_q == S_READ) && in_frame;
      rd_en   = rd_en_c;
      rd_addr = rd_en_c ? addr_c : 15'd0;
   end

   // Scan counters: x fastest, wrap back to x0 at row end with no gap cycle.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         x_q    <= 8'd0;
         y_q    <= 7'd0;
         x0_q   <= 8'd0;
         xend_q <= 8'd0;
         yend_q <= 7'd0;
      end else if (accept) begin
         x_q    <= x0;
         y_q    <= y0;
         x0_q   <= x0;
         xend_q <= x0 + width - 8'd1;
         yend_q <= y0 + height - 7'd1;
      end else if (state_q == S_READ) begin
         if (row_end) begin
            x_q <= x0_q;
            if (!last_pos) y_q <= y_q + 7'd1;
         end else begin
            x_q <= x_q + 8'd1;
         end
      end
   end

   // Read pipeline: delay the strobe and position to line up with rd_data.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pix_valid_q <= 1'b0;
         pix_x_q     <= 8'd0;
         pix_y_q     <= 7'd0;
      end else begin
         pix_valid_q <= rd_en_c;
         if (rd_en_c) begin
            pix_x_q <= x_q;
            pix_y_q <= y_q;
         end
      end
   end

   assign pix_valid = pix_valid_q;
   assign pix_x     = pix_x_q;
   assign pix_y     = pix_y_q;
   // Colour is gated so it reads 0 whenever no pixel is being streamed.
   assign pix_color = pix_valid_q ? rd_data : 3'd0;
   assign dbg_state = state_q;

`ifdef RECT_READER_HIT_COUNT_EN
   logic [14:0] hit_q;
   logic        hit_inc;

   assign hit_inc = pix_valid_q && (rd_data == key_color);

   // Match counter: cleared on accept, holds between scans.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)      hit_q <= 15'd0;
      else if (accept)  hit_q <= 15'd0;
      else if (hit_inc) hit_q <= hit_q + 15'd1;
   end

   // Include the current beat so the count is complete in the done cycle.
   assign hit_count = hit_q + {14'd0, hit_inc};
`else
   logic unused_key;
   assign unused_key = ^key_color;
`endif

endmodule

// File: tb/tb_rect_reader.sv
// Bench for rect_reader: frame buffer model with a 1-cycle synchronous read,
// directed scans with hand-computed pixel streams, and a monitor that pops
// the expected queue on every pix_valid.
module tb_rect_reader;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        go = 1'b0;
   logic [7:0]  x0 = 8'd0;
   logic [6:0]  y0 = 7'd0;
   logic [7:0]  width = 8'd0;
   logic [6:0]  height = 7'd0;
   logic        busy, done, rd_en, pix_valid;
   logic [14:0] rd_addr;
   logic [2:0]  rd_data = 3'd0;
   logic [7:0]  pix_x;
   logic [6:0]  pix_y;
   logic [2:0]  pix_color;
   logic [2:0]  key_color = 3'd0;
   logic [1:0]  dbg_state;
`ifdef RECT_READER_HIT_COUNT_EN
   logic [14:0] hit_count;
   logic [14:0] hit_at_done = 15'd0;
`endif

   rect_reader dut (
      .clk       (clk),
      .resetn    (resetn),
      .go        (go),
      .x0        (x0),
      .y0        (y0),
      .width     (width),
      .height    (height),
      .busy      (busy),
      .done      (done),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .pix_valid (pix_valid),
      .pix_x     (pix_x),
      .pix_y     (pix_y),
      .pix_color (pix_color),
      .key_color (key_color),
`ifdef RECT_READER_HIT_COUNT_EN
      .hit_count (hit_count),
`endif
      .dbg_state (dbg_state)
   );

   // Clock and cycle counter.
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Frame buffer model: synchronous read, one cycle latency.
   logic [2:0] fb [0:160*120-1];
   always @(posedge clk) if (rd_en) rd_data <= fb[rd_addr];

   int checks = 0;
   int failures = 0;
   int go_cyc = 0;
   int rd_cnt = 0;
   int done_cnt = 0;
   int rd_base = 0;
   int done_base = 0;

   // Expected pixel: {absolute cycle, x, y, colour}.
   logic [33:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic push_px(input int rel, input int x, input int y, input int col);
      exp_q.push_back({16'(go_cyc + rel), 8'(x), 7'(y), 3'(col)});
   endtask

   // Monitor: compare every streamed pixel against the scoreboard.
   always @(negedge clk) begin
      if (rd_en) rd_cnt++;
      if (done) begin
         done_cnt++;
`ifdef RECT_READER_HIT_COUNT_EN
         hit_at_done = hit_count;
`endif
      end
      if (pix_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL pix_unexpected actual=(%0d,%0d,c%0d) cyc=%0d required=none",
                     pix_x, pix_y, pix_color, cyc - go_cyc);
         end else begin
            logic [33:0] e;
            e = exp_q.pop_front();
            if ({cyc[15:0], pix_x, pix_y, pix_color} !== e) begin
               failures++;
               $display("FAIL pix_stream actual=(%0d,%0d,c%0d)@%0d required=(%0d,%0d,c%0d)@%0d",
                        pix_x, pix_y, pix_color, cyc, e[17:10], e[9:3], e[2:0], e[33:18]);
            end
         end
      end
   end

   // Issue go in cycle 0; returns at the negedge of cycle 1.
   task automatic start_go(input int ax, input int ay, input int aw, input int ah);
      @(negedge clk);
      x0 = 8'(ax); y0 = 7'(ay); width = 8'(aw); height = 7'(ah);
      go = 1'b1;
      go_cyc = cyc;
      rd_base = rd_cnt;
      done_base = done_cnt;
      @(negedge clk);
      go = 1'b0;
      x0 = 8'd0; y0 = 7'd0; width = 8'd0; height = 7'd0;
   endtask

   // Wait (bounded) for done, check its cycle, idle afterwards and one pulse.
   task automatic wait_done(input string name, input int exp_rel);
      int n;
      n = 0;
      while (!done && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!done) begin
         chk({name, "_done_timeout"}, 32'd0, 32'd1);
      end else begin
         chk({name, "_done_cycle"}, cyc - go_cyc, exp_rel);
         @(negedge clk);
         chk({name, "_busy_after"}, {31'd0, busy}, 0);
         chk({name, "_done_after"}, {31'd0, done}, 0);
      end
      repeat (3) @(negedge clk);
      chk({name, "_done_count"}, done_cnt - done_base, 1);
      chk({name, "_queue_empty"}, exp_q.size(), 0);
   endtask

   initial begin
      for (int y = 0; y < 120; y++)
         for (int x = 0; x < 160; x++)
            fb[y*160 + x] = 3'((x + y) % 8);

      // Reset values.
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_done", {31'd0, done}, 0);
      chk("rst_rd_en", {31'd0, rd_en}, 0);
      chk("rst_pix_valid", {31'd0, pix_valid}, 0);
      chk("rst_rd_addr", {17'd0, rd_addr}, 0);
      chk("rst_pix_xyc", {14'd0, pix_x, pix_y, pix_color}, 0);
      chk("rst_state", {30'd0, dbg_state}, 0);
`ifdef RECT_READER_HIT_COUNT_EN
      chk("rst_hit", {17'd0, hit_count}, 0);
`endif
      resetn = 1'b1;
      repeat (2) @(negedge clk);

      // Basic 3x2 scan.
      start_go(10, 5, 3, 2);
      chk("t1_busy_c1", {31'd0, busy}, 1);
      chk("t1_rd_en_c1", {31'd0, rd_en}, 1);
      chk("t1_rd_addr_c1", {17'd0, rd_addr}, 810);
      push_px(2, 10, 5, 7); push_px(3, 11, 5, 0); push_px(4, 12, 5, 1);
      push_px(5, 10, 6, 0); push_px(6, 11, 6, 1); push_px(7, 12, 6, 2);
      wait_done("t1", 7);
      chk("t1_reads", rd_cnt - rd_base, 6);

      // Zero width: finish immediately, no reads.
      start_go(30, 20, 0, 4);
      chk("t2_done_c1", {31'd0, done}, 1);
      wait_done("t2", 1);
      chk("t2_reads", rd_cnt - rd_base, 0);

      // Bottom-right corner with clipping in x and wrapped-off rows.
      start_go(158, 119, 4, 2);
      chk("t3_rd_addr_c1", {17'd0, rd_addr}, 19198);
      push_px(2, 158, 119, 5); push_px(3, 159, 119, 6);
      wait_done("t3", 9);
      chk("t3_reads", rd_cnt - rd_base, 2);

      // go pulsed again mid-scan is ignored.
      start_go(0, 0, 2, 2);
      push_px(2, 0, 0, 0); push_px(3, 1, 0, 1); push_px(4, 0, 1, 1); push_px(5, 1, 1, 2);
      @(negedge clk);
      @(negedge clk);
      x0 = 8'd50; y0 = 7'd50; width = 8'd3; height = 7'd3; go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      wait_done("t4", 5);
      chk("t4_reads", rd_cnt - rd_base, 4);

      // Reset in cycle 4 of a 5x5 scan abandons it.
      start_go(20, 10, 5, 5);
      push_px(2, 20, 10, 6); push_px(3, 21, 10, 7);
      repeat (3) @(posedge clk);
      #1 resetn = 1'b0;
      @(negedge clk);
      chk("t5_busy_rst", {31'd0, busy}, 0);
      chk("t5_pix_valid_rst", {31'd0, pix_valid}, 0);
      chk("t5_rd_en_rst", {31'd0, rd_en}, 0);
      chk("t5_rd_addr_rst", {17'd0, rd_addr}, 0);
      chk("t5_pix_xy_rst", {17'd0, pix_x, pix_y}, 0);
      repeat (3) @(negedge clk);
      chk("t5_no_done", done_cnt - done_base, 0);
      chk("t5_queue_empty", exp_q.size(), 0);
      resetn = 1'b1;
      @(negedge clk);
      start_go(2, 3, 1, 2);
      push_px(2, 2, 3, 5); push_px(3, 2, 4, 6);
      wait_done("t5b", 3);

`ifdef RECT_READER_HIT_COUNT_EN
      // 4x4 of colour 3 with one colour-5 pixel; key colour 3.
      for (int y = 50; y < 54; y++)
         for (int x = 40; x < 44; x++)
            fb[y*160 + x] = 3'd3;
      fb[51*160 + 41] = 3'd5;
      key_color = 3'd3;
      start_go(40, 50, 4, 4);
      for (int i = 0; i < 16; i++)
         push_px(2 + i, 40 + (i % 4), 50 + (i / 4), ((i % 4) == 1 && (i / 4) == 1) ? 5 : 3);
      wait_done("t6", 17);
      chk("t6_hit_at_done", {17'd0, hit_at_done}, 15);
      chk("t6_hit_held", {17'd0, hit_count}, 15);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global time limit.
   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
